// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq
//   Sequential multiplier / divider.  One shift-add (multiply) or restoring
//   shift-subtract (divide) step per clock on operand magnitudes.  A single
//   FIX cycle then applies sign correction, and FINISH presents the result
//   with a one-cycle done pulse.  Latency from the start edge to the done
//   cycle is WIDTH+2.  A divide by zero skips straight to FINISH, leaves
//   hi/lo untouched and flags div_zero.
//
// Parameters
//   WIDTH      operand / result width (>= 4, even)
//   SIGNED_EN  0 forces unsigned operation regardless of is_signed
//
// Ports
//   clk        clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   start      request pulse, only accepted in IDLE
//   op         0 = multiply, 1 = divide
//   is_signed  1 = two's-complement operands
//   a          multiplicand / dividend
//   b          multiplier / divisor
//   busy       high while CALC or FIX is in progress
//   done       one-cycle completion pulse
//   div_zero   high together with done when the divisor was zero
//   hi         product upper half / remainder
//   lo         product lower half / quotient
// -----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam bit SGN_OK = (SIGNED_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FIX    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_op;
    logic             r_neg_res;   // operand signs differ: negate product / quotient
    logic             r_neg_rem;   // dividend negative: negate remainder
    logic             r_dz;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;       // product upper half / partial remainder
    logic [WIDTH-1:0] r_q;         // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_m;         // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_sgn;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_b_zero;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // ------------------------------------------------------------------
    // Operand preparation (only consumed on the accepting start edge)
    // ------------------------------------------------------------------
    assign w_sgn    = SGN_OK & is_signed;
    assign w_sa     = w_sgn & a[WIDTH-1];
    assign w_sb     = w_sgn & b[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    assign w_mag_a  = w_sa ? -a : a;
    assign w_mag_b  = w_sb ? -b : b;
    assign w_b_zero = (b == '0);

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the {carry, acc, q} chain right by one.
    assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits.  The remainder stays below the
    // divisor, so the difference always fits in WIDTH bits.
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    assign w_diff  = w_shift[WIDTH-1:0] - r_m;

    // Sign correction
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -r_q : r_q;
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op && w_b_zero) ? S_FINISH : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:    w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        unique case (r_state)
            S_CALC,
            S_FIX: begin
                busy = 1'b1;
            end
            S_FINISH: begin
                done     = 1'b1;
                div_zero = r_dz;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // hi/lo are loaded on the FIX->FINISH edge so the result is already
    // visible during the FINISH (done) cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_neg_res <= w_sa ^ w_sb;
                        r_neg_rem <= w_sa;
                        r_dz      <= op & w_b_zero;
                        r_cnt     <= CW'(WIDTH);
                        r_acc     <= '0;
                        if (op) begin
                            r_q <= w_mag_a;
                            r_m <= w_mag_b;
                        end else begin
                            r_q <= w_mag_b;
                            r_m <= w_mag_a;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op) begin
                        r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_op) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mult_div_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_div_seq
//   Self-checking bench for mult_div_seq (WIDTH=32).  A vector table plus a
//   few hand-written sequences drive operations; expected results are pushed
//   to a scoreboard queue when an operation is issued and popped by a monitor
//   on every done pulse.
// -----------------------------------------------------------------------------
module tb_mult_div_seq;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic         op;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;
    logic prev_done  = 1'b0;

    mult_div_seq #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_count++;
            chk("done_not_consecutive", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                chk({e.name, "_dz"}, 64'(div_zero), 64'(e.dz));
            end
        end else if (div_zero) begin
            chk("div_zero_without_done", 64'(div_zero), 64'd0);
        end
        prev_done = done;
    end

    function automatic vec_t mk(input logic o, input logic s, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input logic [W-1:0] eh,
                                input logic [W-1:0] el, input logic ed);
        vec_t v;
        v.op = o; v.sgn = s; v.a = va; v.b = vb;
        v.exp_hi = eh; v.exp_lo = el; v.exp_dz = ed;
        return v;
    endfunction

    // Drive a start for one cycle, queue its expected result.  Returns at the
    // first negedge after the start edge (cycle 1 after start).
    task automatic issue(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        op = v.op; is_signed = v.sgn; a = v.a; b = v.b; start = 1'b1;
        e.hi = v.exp_hi; e.lo = v.exp_lo; e.dz = v.exp_dz; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op = ~v.op; is_signed = ~v.sgn;
    endtask

    task automatic run_op(input vec_t v, input string name);
        int n;
        int exp_lat;
        exp_lat = (v.op && v.b == '0) ? 1 : LAT;
        issue(v, name);
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        int   n;
        int   got_lat;
        int   dc0;
        logic [63:0] p;

        reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // op, signed, a, b, hi, lo, dz
        vecs.push_back(mk(0, 1, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 0));
        vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0));
        vecs.push_back(mk(1, 1, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 0));
        vecs.push_back(mk(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0));
        vecs.push_back(mk(1, 0, 32'd100,      32'd7,       32'd2,        32'd14,       0));
        vecs.push_back(mk(0, 0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0));
        vecs.push_back(mk(1, 1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0));
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0));
        vecs.push_back(mk(1, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0));
        vecs.push_back(mk(0, 0, 32'hFFFFFFFD, 32'd7,       32'h00000006, 32'hFFFFFFEB, 0));
        vecs.push_back(mk(1, 0, 32'd5,        32'd9,       32'd5,        32'd0,        0));
        vecs.push_back(mk(0, 1, 32'h12345678, 32'd0,       32'd0,        32'd0,        0));
        for (int k = 0; k < 6; k++) begin
            v.a = $urandom; v.b = $urandom;
            v.sgn = 1'b0; v.op = k[0]; v.exp_dz = 1'b0;
            if (v.op) begin
                v.b = 32'($urandom_range(1, 32'h0000FFFF));
                v.exp_lo = v.a / v.b;
                v.exp_hi = v.a % v.b;
            end else begin
                p = 64'(v.a) * 64'(v.b);
                v.exp_hi = p[63:32];
                v.exp_lo = p[31:0];
            end
            vecs.push_back(v);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            run_op(vecs[k], $sformatf("vec%0d", k));
        end

        // Divide by zero: preload hi/lo, then expect them unchanged
        run_op(mk(1, 0, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 0), "preload");
        issue(mk(1, 0, 32'd9, 32'd0, 32'h00001234, 32'h00005678, 1), "divzero");
        chk("divzero_done_cycle1", 64'(done), 64'd1);
        chk("divzero_busy_cycle1", 64'(busy), 64'd0);
        @(negedge clk);
        chk("divzero_busy_after", 64'(busy), 64'd0);
        chk("divzero_done_after", 64'(done), 64'd0);

        // Back-to-back starts while busy and in the FINISH cycle are ignored
        dc0 = done_count;
        got_lat = 0;
        issue(mk(0, 1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0), "b2b");
        n = 1;
        for (int k = 0; k < 70; k++) begin
            if (n == 5 || n == 20) begin
                start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd9; b = '0;
            end else if (done && got_lat == 0) begin
                got_lat = n;
                start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd1; b = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b_latency", 64'(got_lat), 64'(LAT));
        chk("b2b_done_count", 64'(done_count - dc0), 64'd1);

        // Reset in the middle of an operation
        issue(mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0), "abort");
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        dc0 = done_count;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_div_zero", 64'(div_zero), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_count - dc0), 64'd0);
        run_op(mk(1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0), "after_abort");

        // Reset wins over a simultaneous start
        dc0 = done_count;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 1'b1; is_signed = 1'b0; a = 32'd9; b = '0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("prio_busy", 64'(busy), 64'd0);
        chk("prio_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        chk("prio_no_done", 64'(done_count - dc0), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have these parameters:
- WIDTH, default 32, operand/result width (>=4, even).
- SIGNED_EN, default 1; when 0, is_signed is ignored and treated as 0.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0=multiply, 1=divide
- is_signed  in  1  1=two's-complement operands
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  high with done when divisor was zero
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient

Function
REQ-004 The FSM SHALL have the states IDLE, CALC, FIX and FINISH.
REQ-005 IDLE with start=1 at edge T:
- latch op, effective signedness, and the operand magnitudes and signs;
- load iteration counter = WIDTH;
- enter CALC; busy=1 from the cycle after T.
REQ-006 CALC SHALL perform one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle and decrement the counter, leaving after exactly WIDTH cycles to FIX.
REQ-007 FIX SHALL apply sign correction in one cycle, then go to FINISH.
- Multiply: negate the 2*WIDTH product if the operand signs differ.
- Divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
REQ-008 FINISH SHALL, in one cycle:
- write hi/lo;
- assert done=1 and deassert busy;
- return to IDLE.
Total latency from the start edge to the done cycle SHALL be WIDTH+2 cycles.
REQ-009 Multiply results SHALL be {hi,lo} = the full 2*WIDTH product; no overflow SHALL be flagged.
REQ-010 Divide results SHALL be lo=quotient (truncated toward zero) and hi=remainder.
REQ-011 Signed divide of -2^(WIDTH-1) by -1 SHALL give lo=-2^(WIDTH-1) (wrap) and hi=0, with no flag.
REQ-012 Divide with b=0 SHALL skip CALC and FIX and go directly to FINISH on the edge after start. In FINISH: done=1, div_zero=1, and hi/lo are left unchanged.
REQ-013 div_zero SHALL be 0 on every other done pulse, and 0 whenever done=0.
REQ-014 start asserted while busy=1 SHALL be ignored; operand inputs SHALL be ignored outside the start edge.
REQ-015 hi/lo SHALL hold their last written value until the next FINISH that writes them; done SHALL never be high for two consecutive cycles.
REQ-016 start asserted in the same cycle FINISH completes SHALL be ignored; a new operation requires start with the FSM in IDLE.
REQ-017 When SIGNED_EN=0, or is_signed=0, operands SHALL be treated as unsigned and FIX SHALL perform no negation.

Reset
REQ-018 With reset=1 at a clock edge, the following SHALL hold regardless of state, including mid-operation:
- FSM goes to IDLE;
- busy=0, done=0, div_zero=0, hi=0, lo=0;
- counter and internal operand registers are cleared.
REQ-019 reset SHALL take priority over start in the same cycle.
REQ-020 Outputs SHALL be deterministic from the first reset edge; no initial-block dependence.

Verification (WIDTH=32)
REQ-021 Signed multiply: a=-3 (0xFFFFFFFD), b=7, start -> done at cycle 34 after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-022 Unsigned multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-023 Signed divide:
- a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-024 Divide by zero: preload hi/lo=0x1234/0x5678, then a=9, b=0, op=1 -> done and div_zero high one cycle after start; hi/lo unchanged; busy never high for more than that single cycle.
REQ-025 Back-to-back and abort:
- start pulses at cycles 5 and 20 of an op are ignored; exactly one done is produced.
- reset at cycle 10 of an op -> no done; all outputs 0 next cycle; a fresh start then completes normally in 34 cycles.
